// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_responder data-memory slave.
package dmem_pkg;

  // Responder FSM: idle, counting wait states, presenting the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES = 4;

  // Error codes carried on dmem_err_o.
  localparam logic DMEM_ERR_NONE = 1'b0;
  localparam logic DMEM_ERR_ADDR = 1'b1;

endpackage

// File: rtl/dmem_sram_array.sv
// dmem_sram_array: single-port word array split into byte lanes, per-lane
// write enable, registered read port (read-before-write on the same edge).
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  // One independent byte-wide memory per lane keeps each lane's write port
  // in its own process, which maps cleanly onto byte-enable block RAM.
  for (genvar gi = 0; gi < DMEM_WORD_BYTES; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_rdata;

    // Lane access: optional byte write plus registered read of the old value.
    always_ff @(posedge clk_i) begin
      if (i_en) begin
        if (i_we && i_be[gi]) begin
          r_mem[i_idx] <= i_wdata[8*gi +: 8];
        end
        r_rdata <= r_mem[i_idx];
      end
    end

    assign o_rdata[8*gi +: 8] = r_rdata;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory slave with WAIT_CYCLES wait states
// between acceptance and the array access, one-cycle response, address error
// detection. Optional macro DMEM_STRB_EN enables byte-strobe writes; without
// it every write updates the full word and dmem_strb_i is ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_req_i,
  input  logic        dmem_wen_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_strb_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_err_o
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(DMEM_WORD_BYTES);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_rvalid;
  logic        r_err;
  logic        r_rd_ok;

  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic             w_gnt;
  logic             w_accept;
  logic             w_access;
  logic             w_src_wen;
  logic [31:0]      w_src_addr;
  logic [31:0]      w_src_wdata;
  logic [31:0]      w_offset;
  logic             w_src_err;
  logic [3:0]       w_be;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_sram_rdata;

  assign w_gnt    = (r_state != WAIT);
  assign w_accept = dmem_req_i && w_gnt;

  // With no wait states the access happens on the acceptance edge itself,
  // so the array must see the live request rather than the latched copy.
  assign w_src_wen   = NO_WAIT ? dmem_wen_i   : r_wen;
  assign w_src_addr  = NO_WAIT ? dmem_addr_i  : r_addr;
  assign w_src_wdata = NO_WAIT ? dmem_wdata_i : r_wdata;

  // BASE_ADDR is aligned, so the offset's low bits equal the address's.
  assign w_offset  = w_src_addr - BASE_ADDR;
  assign w_src_err = ((w_offset[1:0] != 2'b00) || ({1'b0, w_offset} >= SPAN_BYTES))
                     ? DMEM_ERR_ADDR : DMEM_ERR_NONE;
  assign w_idx     = w_offset[IDX_W+1:2];

  // The access edge is the one entering RESP; reset on that edge cancels it.
  assign w_access = rst_i &&
                    (((r_state == WAIT) && (r_cnt == 4'd0)) || (w_accept && NO_WAIT));

`ifdef DMEM_STRB_EN
  logic [3:0] r_strb;

  // Keep the strobes alongside the rest of the accepted request.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_strb <= dmem_strb_i;
    end
  end

  assign w_be = NO_WAIT ? dmem_strb_i : r_strb;
`else
  logic w_unused_strb;
  assign w_unused_strb = ^dmem_strb_i;
  assign w_be          = 4'hF;
`endif

  // Capture the request on acceptance; consumed at the access edge.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_wen   <= dmem_wen_i;
      r_addr  <= dmem_addr_i;
      r_wdata <= dmem_wdata_i;
    end
  end

  // FSM, wait-state counter and response flags.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd_ok  <= 1'b0;
    end else begin
      r_rvalid <= w_access;
      r_err    <= w_access && w_src_err;
      r_rd_ok  <= w_access && !w_src_wen && !w_src_err;
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            if (NO_WAIT) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk_i  (clk_i),
    .i_en   (w_access),
    .i_we   (w_src_wen && !w_src_err),
    .i_be   (w_be),
    .i_idx  (w_idx),
    .i_wdata(w_src_wdata),
    .o_rdata(w_sram_rdata)
  );

  assign dmem_gnt_o    = w_gnt;
  assign dmem_rvalid_o = r_rvalid;
  assign dmem_err_o    = r_err;
  assign dmem_rdata_o  = r_rd_ok ? w_sram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: four responders with WAIT_CYCLES = 0..3 (instance k has
// k wait states), exercised one at a time against a scoreboard of expected
// responses and a small reference memory.
module tb_dmem_responder;

  localparam int NI = 4;
  localparam int DW = 16;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic [3:0]  rst_n;
  logic [3:0]  req;
  logic [3:0]  wen;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [3:0]  err;
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic [3:0]  strb  [NI];

  logic [31:0] mdl [NI][DW];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rv_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DW),
      .WAIT_CYCLES(gi),
      .BASE_ADDR  (32'h0000_0000)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_n[gi]),
      .dmem_req_i   (req[gi]),
      .dmem_wen_i   (wen[gi]),
      .dmem_addr_i  (addr[gi]),
      .dmem_wdata_i (wdata[gi]),
      .dmem_strb_i  (strb[gi]),
      .dmem_gnt_o   (gnt[gi]),
      .dmem_rvalid_o(rvalid[gi]),
      .dmem_rdata_o (rdata[gi]),
      .dmem_err_o   (err[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge, hold it until granted, then drop it.
  // When track is set the expected response is queued and the model updated.
  task automatic drive(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit track);
    int   n = 0;
    exp_t e;
    logic bad;
    req[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d; strb[k] = s;
    while (!gnt[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!gnt[k]) begin
      check("gnt_timeout", 32'd0, 32'd1);
      req[k] = 1'b0;
      return;
    end
    if (track) begin
      bad     = (a[1:0] != 2'b00) || (a >= 32'(DW * 4));
      e.inst  = k;
      e.err   = bad;
      e.rdata = (w || bad) ? 32'h0 : mdl[k][a[5:2]];
      if (w && !bad) begin
`ifdef DMEM_STRB_EN
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mdl[k][a[5:2]][8*b +: 8] = d[8*b +: 8];
        end
`else
        mdl[k][a[5:2]] = d;
`endif
      end
      sb_q.push_back(e);
    end
    @(negedge clk);
    req[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Response monitor: every rvalid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (rvalid[k] === 1'b1) begin
        rv_cnt++;
        $display("rsp inst=%0d rdata=%h err=%b", k, rdata[k], err[k]);
        if (sb_q.size() == 0) begin
          check("spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_inst", 32'(k), 32'(e.inst));
          check("rsp_rdata", rdata[k], e.rdata);
          check("rsp_err", 32'(err[k]), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int rv0;
    rst_n = 4'h0; req = 4'h0; wen = 4'h0;
    for (int k = 0; k < NI; k++) begin
      addr[k] = 32'h0; wdata[k] = 32'h0; strb[k] = 4'hF;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_gnt", 32'(gnt[k]), 32'd1);
      check("reset_rvalid", 32'(rvalid[k]), 32'd0);
      check("reset_rdata", rdata[k], 32'h0);
      check("reset_err", 32'(err[k]), 32'd0);
    end
    rst_n = 4'hF;
    @(negedge clk);

    // Two wait states: grant drops for two cycles, response in the third.
    drive(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    check("w2_gnt_c1", 32'(gnt[2]), 32'd0);
    check("w2_rvalid_c1", 32'(rvalid[2]), 32'd0);
    @(negedge clk);
    check("w2_gnt_c2", 32'(gnt[2]), 32'd0);
    check("w2_rvalid_c2", 32'(rvalid[2]), 32'd0);
    @(negedge clk);
    check("w2_rvalid_c3", 32'(rvalid[2]), 32'd1);
    check("w2_wr_rdata", rdata[2], 32'h0);
    check("w2_wr_err", 32'(err[2]), 32'd0);
    drive(2, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    drain();

    // Zero wait states: write then read accepted in RESP, back-to-back responses.
    drive(0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 1'b1);
    check("w0_rvalid_1", 32'(rvalid[0]), 32'd1);
    drive(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1);
    check("w0_rvalid_2", 32'(rvalid[0]), 32'd1);
    check("w0_raw_rdata", rdata[0], 32'h1234_5678);
    drain();

    // Address errors: misaligned, one past the end, write that must not land.
    drive(2, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b1);
    drive(2, 1'b0, 32'h6, 32'h0, 4'hF, 1'b1);
    drive(2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1);
    drive(2, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1);
    drive(2, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
    drain();

    // Reset during the second wait cycle drops the write and its response.
    drive(3, 1'b1, 32'h20, 32'h5555_AAAA, 4'hF, 1'b1);
    drain();
    drive(3, 1'b1, 32'h20, 32'h0BAD_0BAD, 4'hF, 1'b0);
    @(negedge clk);
    rst_n[3] = 1'b0;
    @(negedge clk);
    rst_n[3] = 1'b1;
    check("rst_wait_gnt", 32'(gnt[3]), 32'd1);
    check("rst_wait_rvalid", 32'(rvalid[3]), 32'd0);
    repeat (8) @(negedge clk);
    drive(3, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1);
    drain();

    // Byte strobes (full-word writes when the strobe feature is compiled out).
    drive(1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, 1'b1);
    drive(1, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 1'b1);
    drive(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1);
    drive(1, 1'b1, 32'h8, 32'h5566_7788, 4'b0000, 1'b1);
    drive(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1);
    drain();

    // Request held high for 10 cycles with one wait state: 5 transactions.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 32'(i * 4), 32'h100 + 32'(i), 4'hF, 1'b1);
    end
    drain();
    acc = 0;
    rv0 = rv_cnt;
    req[1] = 1'b1; wen[1] = 1'b0; strb[1] = 4'hF;
    for (int c = 0; c < 10; c++) begin
      addr[1] = 32'(acc * 4);
      if (gnt[1]) begin
        sb_q.push_back('{inst: 1, rdata: mdl[1][acc], err: 1'b0});
        acc++;
      end
      @(negedge clk);
    end
    req[1] = 1'b0;
    drain();
    check("tput_accepts", 32'(acc), 32'd5);
    check("tput_rvalids", 32'(rv_cnt - rv0), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave on the far end of the Memory-stage dmem port: accepts requests, performs the word access after a programmable number of wait states, and returns a one-cycle response.
- Replaces the ideal combinational dmem with a handshaked, latency-bearing target so that stall paths (exec_ready/wb_ready) get exercised.
- Sits between the Memory stage (initiator) and on-chip SRAM.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 1: wait states between acceptance and access; 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset (0 = reset).
- dmem_req_i  in  1  request valid.
- dmem_wen_i  in  1  1 = write, 0 = read; sampled with the request.
- dmem_addr_i  in  32  byte address.
- dmem_wdata_i  in  32  write data.
- dmem_strb_i  in  4  byte strobes; used only with DMEM_STRB_EN.
- dmem_gnt_o  out  1  request accepted this cycle when req_i & gnt_o.
- dmem_rvalid_o  out  1  response valid, exactly one cycle per accepted request.
- dmem_rdata_o  out  32  read data; 0 on write or error responses.
- dmem_err_o  out  1  error flag, qualified by rvalid_o.

Behaviour:
- Reset (rst_i = 0 at an edge):
  - state = IDLE, counter = 0.
  - rvalid_o = 0, rdata_o = 0, err_o = 0.
  - gnt_o = 1 after reset (state IDLE).
  - Memory contents are neither reset nor altered.
- FSM states IDLE, WAIT, RESP.
- gnt_o is 1 in IDLE or RESP and 0 in WAIT. It is purely state-decoded and never depends on req_i.
- Acceptance (req_i & gnt_o at an edge):
  - Latch wen, addr, wdata and strb.
  - If WAIT_CYCLES = 0, go to RESP. Otherwise go to WAIT with counter = WAIT_CYCLES - 1.
- WAIT: decrement counter each edge. At counter = 0, the next edge goes to RESP.
- Access edge = the edge entering RESP. On this edge:
  - Write commits to the array.
  - Read data is registered into rdata_o.
  - err_o is set.
- RESP:
  - rvalid_o = 1 for this single cycle.
  - Next edge: if a new request is accepted, follow the acceptance rule; otherwise go to IDLE with rvalid_o = 0.
- Latency: acceptance edge to rvalid_o high = WAIT_CYCLES + 1 cycles.
- Sustained throughput: one transaction per WAIT_CYCLES + 1 cycles.
- Error condition: addr[1:0] != 0, or (addr - BASE_ADDR) >= DEPTH_WORDS*4 (unsigned, 32-bit wrap). On error: no write occurs, rdata_o = 0, err_o = 1 with rvalid_o.
- Index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits. It is used only after the range check passes.
- Ordering:
  - A read accepted in RESP immediately after a write to the same word returns the newly written data.
  - Requests complete strictly in order; at most one is outstanding.
- req_i held high while gnt_o = 0 is ignored; it is not queued.
- Reset asserted in WAIT drops the transaction: no write, no response. Reset asserted in RESP drops the pending rvalid_o.

Optional Feature:
- Macro DMEM_STRB_EN.
- Defined: a write updates only byte lanes whose dmem_strb_i bit is 1. A strobe value of 4'b0000 writes nothing but still responds with rvalid_o = 1, err_o = 0. Reads ignore the strobes.
- Undefined: every write updates the full word, and dmem_strb_i is unconnected internally.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] dmem_state_t {IDLE, WAIT, RESP}.
  - localparam DMEM_WORD_BYTES = 4.
  - Error-code constant DMEM_ERR_NONE / DMEM_ERR_ADDR.
- Sub-module dmem_sram_array: synchronous single-port array with per-byte write enable (all-ones when DMEM_STRB_EN is undefined) and a registered read port. The FSM, counter and range check stay in dmem_responder.

Test Plan:
- WAIT_CYCLES = 2. Write 32'hDEAD_BEEF to 0x10 accepted at cycle 0 → gnt_o = 0 during cycles 1–2, rvalid_o = 1 at cycle 3, err_o = 0, rdata_o = 0. A subsequent read of 0x10 returns 32'hDEAD_BEEF.
- WAIT_CYCLES = 0. Write 0x4 = 32'h1234_5678, then read 0x4 on consecutive edges → read accepted in RESP, rvalid_o high two cycles in a row, second rdata_o = 32'h1234_5678.
- Read of 0x6 (misaligned) and of BASE_ADDR + DEPTH_WORDS*4 → rvalid_o = 1, err_o = 1, rdata_o = 0. A write to the same out-of-range address leaves word 0 unchanged.
- WAIT_CYCLES = 3. Accept a write to 0x20, assert rst_i = 0 in the second WAIT cycle → no rvalid_o, gnt_o = 1 after reset, read of 0x20 returns its old value.
- DMEM_STRB_EN defined, word 0x8 = 32'hAABB_CCDD. Write 32'h1122_3344 with strb = 4'b0101 → read returns 32'hAA22_CC44. Write with strb = 4'b0000 → read still returns 32'hAA22_CC44.
- req_i held high for 10 cycles with WAIT_CYCLES = 1 → exactly 5 acceptances and 5 rvalid_o pulses, in order.
